// File: rtl/i2c_slave_mem.sv
// I2C slave with a byte-wide register memory and an auto-incrementing pointer.
// Define I2C_SLAVE_GLITCH_FILTER_EN to add a 3-sample majority filter on SCL and SDA.
module i2c_slave_mem #(
   parameter logic [6:0]  SLAVE_ADDR = 7'h50,
   parameter int unsigned MEM_DEPTH  = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic scl,
   inout  wire  sda,
   output logic busy,
   output logic wr_pulse,
   output logic rd_pulse,
   output logic rx_status
);

   localparam int unsigned PtrW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   typedef enum logic [3:0] {
      StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
      StWdata, StWdataAck, StRdata, StRdAck, StIgnore
   } state_e;

   logic [1:0] scl_sync_q, sda_sync_q;
   logic       scl_f, sda_f;
   logic       scl_prev_q, sda_prev_q;
   logic       scl_rise, scl_fall, start_det, stop_det;

   state_e          state_q, state_d;
   logic [3:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shreg_q, shreg_d;
   logic [7:0]      tx_q, tx_d;
   logic [PtrW-1:0] ptr_q, ptr_d, ptr_inc;
   logic            sda_oe_q, sda_oe_d;
   logic            busy_q, busy_d;
   logic            rx_status_q, rx_status_d;
   logic            wr_pulse_q, rd_pulse_q;
   logic            mem_we, rd_load;
   logic [7:0]      byte_in;
   logic [7:0]      mem_q [MEM_DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync_q <= '0;
         sda_sync_q <= '0;
      end else begin
         scl_sync_q <= {scl_sync_q[0], scl};
         sda_sync_q <= {sda_sync_q[0], sda};
      end
   end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
   logic [2:0] scl_filt_q, sda_filt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_filt_q <= '0;
         sda_filt_q <= '0;
      end else begin
         scl_filt_q <= {scl_filt_q[1:0], scl_sync_q[1]};
         sda_filt_q <= {sda_filt_q[1:0], sda_sync_q[1]};
      end
   end

   assign scl_f = (scl_filt_q[0] & scl_filt_q[1]) | (scl_filt_q[1] & scl_filt_q[2]) |
                  (scl_filt_q[0] & scl_filt_q[2]);
   assign sda_f = (sda_filt_q[0] & sda_filt_q[1]) | (sda_filt_q[1] & sda_filt_q[2]) |
                  (sda_filt_q[0] & sda_filt_q[2]);
`else
   assign scl_f = scl_sync_q[1];
   assign sda_f = sda_sync_q[1];
`endif

   assign scl_rise  = scl_f & ~scl_prev_q;
   assign scl_fall  = ~scl_f & scl_prev_q;
   // SDA may only move while SCL is low; any move with SCL held high is a bus condition.
   assign start_det = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
   assign stop_det  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;

   assign byte_in = {shreg_q[6:0], sda_f};
   assign ptr_inc = (ptr_q == PtrW'(MEM_DEPTH - 1)) ? '0 : ptr_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      tx_d        = tx_q;
      ptr_d       = ptr_q;
      sda_oe_d    = sda_oe_q;
      busy_d      = busy_q;
      mem_we      = 1'b0;
      rd_load     = 1'b0;

      if (stop_det) begin
         state_d   = StIdle;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
         bit_cnt_d = '0;
      end else if (start_det) begin
         state_d   = StAddr;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
         bit_cnt_d = '0;
      end else begin
         case (state_q)
            StAddr, StPtr, StWdata: begin
               if (scl_rise && bit_cnt_q < 4'd8) begin
                  shreg_d   = byte_in;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     if (state_q == StPtr) begin
                        ptr_d = byte_in[PtrW-1:0];
                     end else if (state_q == StWdata) begin
                        mem_we = 1'b1;
                        ptr_d  = ptr_inc;
                     end
                  end
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  bit_cnt_d = '0;
                  if (state_q == StAddr) begin
                     if (shreg_q[7:1] == SLAVE_ADDR) begin
                        state_d  = StAddrAck;
                        sda_oe_d = 1'b1;
                        busy_d   = 1'b1;
                     end else begin
                        state_d = StIgnore;
                     end
                  end else begin
                     state_d  = (state_q == StPtr) ? StPtrAck : StWdataAck;
                     sda_oe_d = 1'b1;
                  end
               end
            end
            StAddrAck, StPtrAck, StWdataAck: begin
               if (scl_fall) begin
                  sda_oe_d = 1'b0;
                  if (state_q == StAddrAck && shreg_q[0]) begin
                     rd_load = 1'b1;
                  end else if (state_q == StAddrAck) begin
                     state_d = StPtr;
                  end else begin
                     state_d = StWdata;
                  end
               end
            end
            StRdata: begin
               if (scl_rise && bit_cnt_q < 4'd8) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     state_d   = StRdAck;
                     sda_oe_d  = 1'b0;
                     bit_cnt_d = '0;
                  end else begin
                     tx_d     = {tx_q[6:0], 1'b0};
                     sda_oe_d = ~tx_q[6];
                  end
               end
            end
            StRdAck: begin
               if (scl_rise) begin
                  shreg_d = byte_in;
               end else if (scl_fall) begin
                  if (!shreg_q[0]) begin
                     rd_load = 1'b1;
                  end else begin
                     state_d = StIgnore;
                  end
               end
            end
            default: ;
         endcase
      end

      // First bit goes out on the same SCL fall that enters RDATA.
      if (rd_load) begin
         state_d   = StRdata;
         tx_d      = mem_q[ptr_q];
         sda_oe_d  = ~mem_q[ptr_q][7];
         ptr_d     = ptr_inc;
         bit_cnt_d = '0;
      end

      rx_status_d = rx_status_q | (mem_we && int'(ptr_q) == 63 && byte_in == 8'd63);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_prev_q  <= 1'b0;
         sda_prev_q  <= 1'b0;
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         tx_q        <= '0;
         ptr_q       <= '0;
         sda_oe_q    <= 1'b0;
         busy_q      <= 1'b0;
         rx_status_q <= 1'b0;
         wr_pulse_q  <= 1'b0;
         rd_pulse_q  <= 1'b0;
      end else begin
         scl_prev_q  <= scl_f;
         sda_prev_q  <= sda_f;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         tx_q        <= tx_d;
         ptr_q       <= ptr_d;
         sda_oe_q    <= sda_oe_d;
         busy_q      <= busy_d;
         rx_status_q <= rx_status_d;
         wr_pulse_q  <= mem_we;
         rd_pulse_q  <= rd_load;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (mem_we) begin
         mem_q[ptr_q] <= byte_in;
      end
   end

   assign sda       = sda_oe_q ? 1'b0 : 1'bz;
   assign busy      = busy_q;
   assign wr_pulse  = wr_pulse_q;
   assign rd_pulse  = rd_pulse_q;
   assign rx_status = rx_status_q;

endmodule
